// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b types: BHT counter encoding, redirect FSM states, CC generation
package lc3b_types;

  typedef logic [1:0] lc3b_bht_counter;

  localparam lc3b_bht_counter BHT_STRONG_NT = 2'b00;
  localparam lc3b_bht_counter BHT_WEAK_NT   = 2'b01;
  localparam lc3b_bht_counter BHT_STRONG_T  = 2'b11;

  typedef enum logic {
    RD_IDLE,
    RD_PENDING
  } lc3b_redirect_state;

  // One-hot NZP from a result value
  function automatic logic [2:0] gen_cc(input logic [15:0] data);
    if (data[15])
      return 3'b100;
    else if (data == 16'h0000)
      return 3'b010;
    else
      return 3'b001;
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// rtl/branch_history_table.sv - 2-bit saturating counter array, async read, saturating update
module branch_history_table
  import lc3b_types::*;
#(
  parameter int IDX_BITS = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_taken,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);

  localparam int ENTRIES = 1 << IDX_BITS;

  lc3b_bht_counter ctr_q [ENTRIES];

  // Read sees the pre-update value when it hits the entry being written
  assign rd_taken = ctr_q[rd_idx][1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BHT_WEAK_NT;
    end else if (wr_en) begin
      if (wr_taken) begin
        if (ctr_q[wr_idx] != BHT_STRONG_T) ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'd1;
      end else begin
        if (ctr_q[wr_idx] != BHT_STRONG_NT) ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/ex_branch_resolve.sv
// rtl/ex_branch_resolve.sv - EX-stage branch resolution: NZP register, BHT, flush and fetch redirect
module ex_branch_resolve
  import lc3b_types::*;
#(
  parameter int BHT_IDX_BITS = 3,
  parameter int STAT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ex_advance,
  input  logic                  ex_is_nop,
  input  logic                  ex_is_br,
  input  logic                  ex_is_uncond,
  input  logic [2:0]            ex_ir_nzp,
  input  logic                  ex_pred_taken,
  input  logic [15:0]           ex_btb_target,
  input  logic [15:0]           ex_flush_pc,
  input  logic [15:0]           ex_target_pc,
  input  logic [15:0]           ex_pc,
  input  logic                  cc_load,
  input  logic [15:0]           cc_data,
  input  logic [15:0]           if_pc,
  output logic                  if_bht_taken,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [15:0]           redirect_pc,
  input  logic                  redirect_ack,
  output logic [2:0]            cc_out,
  output logic [STAT_WIDTH-1:0] br_count,
  output logic [STAT_WIDTH-1:0] mispred_count
);

  logic [2:0]            cc_q;
  logic [2:0]            eff_cc;
  lc3b_redirect_state    state_q, state_d;
  logic [15:0]           pend_pc_q;
  logic                  pend_load;
  logic                  resolve, taken, mispredict;
  logic [15:0]           correct_pc;
  logic [STAT_WIDTH-1:0] br_q, mis_q;

  // An older instruction writing CC this cycle is forwarded to the branch
  assign eff_cc = cc_load ? gen_cc(cc_data) : cc_q;

  assign resolve = ex_advance & ~ex_is_nop & (ex_is_br | ex_is_uncond) & (state_q == RD_IDLE);
  assign taken   = ex_is_uncond | (|(ex_ir_nzp & eff_cc));
  assign mispredict = resolve & ((taken != ex_pred_taken) |
                                 (taken & ex_pred_taken & (ex_btb_target != ex_target_pc)));
  assign correct_pc = taken ? ex_target_pc : ex_flush_pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cc_q <= 3'b010;
    else if (cc_load) cc_q <= gen_cc(cc_data);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RD_IDLE;
      pend_pc_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (pend_load) pend_pc_q <= correct_pc;
    end
  end

  always_comb begin
    state_d        = state_q;
    pend_load      = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    case (state_q)
      RD_IDLE: begin
        flush          = mispredict;
        redirect_valid = mispredict;
        if (mispredict) redirect_pc = correct_pc;
        if (mispredict && !redirect_ack) begin
          pend_load = 1'b1;
          state_d   = RD_PENDING;
        end
      end
      RD_PENDING: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = pend_pc_q;
        if (redirect_ack) state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      if (resolve && br_q != '1)     br_q  <= br_q + STAT_WIDTH'(1);
      if (mispredict && mis_q != '1) mis_q <= mis_q + STAT_WIDTH'(1);
    end
  end

  assign cc_out        = cc_q;
  assign br_count      = br_q;
  assign mispred_count = mis_q;

  branch_history_table #(
    .IDX_BITS(BHT_IDX_BITS)
  ) u_bht (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_idx   (if_pc[BHT_IDX_BITS:1]),
    .rd_taken (if_bht_taken),
    .wr_en    (resolve & ex_is_br),
    .wr_idx   (ex_pc[BHT_IDX_BITS:1]),
    .wr_taken (taken)
  );

endmodule

// File: tb/tb_ex_branch_resolve.sv
// tb/tb_ex_branch_resolve.sv - scoreboard bench for ex_branch_resolve against a behavioural model
module tb_ex_branch_resolve;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_advance, ex_is_nop, ex_is_br, ex_is_uncond;
  logic [2:0]  ex_ir_nzp;
  logic        ex_pred_taken;
  logic [15:0] ex_btb_target, ex_flush_pc, ex_target_pc, ex_pc;
  logic        cc_load;
  logic [15:0] cc_data, if_pc;
  logic        if_bht_taken, flush, redirect_valid, redirect_ack;
  logic [15:0] redirect_pc;
  logic [2:0]  cc_out;
  logic [15:0] br_count, mispred_count;

  always #5 clk = ~clk;

  ex_branch_resolve #(.BHT_IDX_BITS(3), .STAT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .ex_advance(ex_advance), .ex_is_nop(ex_is_nop),
    .ex_is_br(ex_is_br), .ex_is_uncond(ex_is_uncond), .ex_ir_nzp(ex_ir_nzp),
    .ex_pred_taken(ex_pred_taken), .ex_btb_target(ex_btb_target), .ex_flush_pc(ex_flush_pc),
    .ex_target_pc(ex_target_pc), .ex_pc(ex_pc), .cc_load(cc_load), .cc_data(cc_data),
    .if_pc(if_pc), .if_bht_taken(if_bht_taken), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ack(redirect_ack), .cc_out(cc_out),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  typedef struct {
    bit adv, nop, br, unc;
    bit [2:0] nzp;
    bit pred;
    bit [15:0] btb, fpc, tpc, pc;
    bit ccl;
    bit [15:0] ccd, ifpc;
    bit ack;
  } stim_t;

  typedef struct {
    bit flush, rv;
    bit [15:0] rpc;
    bit [2:0] cc;
    int br, mis;
    bit bht;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference state
  bit [2:0]  m_cc;
  int        m_bht[8];
  bit        m_pend;
  bit [15:0] m_ppc;
  int        m_br, m_mis;

  function automatic void model_reset();
    m_cc = 3'b010;
    foreach (m_bht[i]) m_bht[i] = 1;
    m_pend = 0; m_ppc = 0; m_br = 0; m_mis = 0;
  endfunction

  function automatic bit [2:0] ref_cc(input bit [15:0] d);
    if ($signed(d) < 0) return 3'b100;
    if (d == 0) return 3'b010;
    return 3'b001;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, req);
    end
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t br_stim(input bit [2:0] nzp, input bit pred, input bit [15:0] btb,
                                    input bit [15:0] tpc, input bit [15:0] fpc, input bit [15:0] pc);
    stim_t s;
    s = idle_stim();
    s.adv = 1; s.br = 1; s.nzp = nzp; s.pred = pred;
    s.btb = btb; s.tpc = tpc; s.fpc = fpc; s.pc = pc; s.ifpc = pc; s.ack = 1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    ex_advance = s.adv; ex_is_nop = s.nop; ex_is_br = s.br; ex_is_uncond = s.unc;
    ex_ir_nzp = s.nzp; ex_pred_taken = s.pred; ex_btb_target = s.btb;
    ex_flush_pc = s.fpc; ex_target_pc = s.tpc; ex_pc = s.pc;
    cc_load = s.ccl; cc_data = s.ccd; if_pc = s.ifpc; redirect_ack = s.ack;
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    bit [2:0] eff;
    bit res, tk, mp;
    bit [15:0] cpc;
    int idx;
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive(s);
    eff = s.ccl ? ref_cc(s.ccd) : m_cc;
    res = s.adv && !s.nop && (s.br || s.unc) && !m_pend;
    tk  = s.unc || ((s.nzp & eff) != 0);
    mp  = res && ((tk != s.pred) || (tk && s.pred && s.btb != s.tpc));
    cpc = tk ? s.tpc : s.fpc;
    e.flush = m_pend || mp;
    e.rv    = m_pend || mp;
    e.rpc   = m_pend ? m_ppc : cpc;
    e.cc    = m_cc;
    e.br    = m_br;
    e.mis   = m_mis;
    e.bht   = m_bht[(s.ifpc / 2) % 8] >= 2;
    exp_q.push_back(e);
    if (s.ccl) m_cc = ref_cc(s.ccd);
    if (res && s.br) begin
      idx = (s.pc / 2) % 8;
      if (tk) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
      else    m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
    end
    if (res && m_br < 65535) m_br++;
    if (mp && m_mis < 65535) m_mis++;
    if (m_pend) begin
      if (s.ack) m_pend = 0;
    end else if (mp && !s.ack) begin
      m_pend = 1;
      m_ppc  = cpc;
    end
  endtask

  task automatic do_reset();
    exp_t e;
    @(posedge clk); #1;
    reset_n = 1'b0;
    drive(idle_stim());
    model_reset();
    e = '{flush: 0, rv: 0, rpc: 0, cc: 3'b010, br: 0, mis: 0, bht: 0};
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("flush", 32'(flush), 32'(e.flush));
        chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
        if (e.rv) chk("redirect_pc", 32'(redirect_pc), 32'(e.rpc));
        chk("cc_out", 32'(cc_out), 32'(e.cc));
        chk("br_count", 32'(br_count), e.br);
        chk("mispred_count", 32'(mispred_count), e.mis);
        chk("if_bht_taken", 32'(if_bht_taken), 32'(e.bht));
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    reset_n = 1'b0;
    drive(idle_stim());
    model_reset();
    repeat (3) @(posedge clk);

    // Correctly predicted taken BR, then observe its BHT entry
    step(br_stim(3'b010, 1, 16'h3000, 16'h3000, 16'h0006, 16'h0004));
    s = idle_stim(); s.ifpc = 16'h0004; step(s);

    // Predicted taken, actually not taken, accepted at once
    step(br_stim(3'b100, 1, 16'h1100, 16'h1100, 16'h1006, 16'h1004));
    step(idle_stim());

    // Unconditional with wrong BTB target, ack held low three cycles
    s = idle_stim();
    s.adv = 1; s.unc = 1; s.pred = 1; s.btb = 16'h2000; s.tpc = 16'h2400;
    s.fpc = 16'h0102; s.pc = 16'h0100; s.ack = 0;
    step(s); step(s); step(s);
    s.ack = 1; step(s);
    step(idle_stim());

    // Bypassed N makes the branch taken
    s = br_stim(3'b100, 0, 16'h0000, 16'h4444, 16'h0012, 16'h0010);
    s.ccl = 1; s.ccd = 16'h8000;
    step(s);
    step(idle_stim());

    // Saturation: five taken BRs at the same index
    repeat (5) step(br_stim(3'b111, 1, 16'h5000, 16'h5000, 16'h000a, 16'h0008));
    s = idle_stim(); s.ifpc = 16'h0008; step(s);

    // Stall twice then advance
    s = br_stim(3'b111, 1, 16'h6000, 16'h6000, 16'h000e, 16'h000c);
    s.adv = 0; step(s); step(s);
    s.adv = 1; step(s);
    s = idle_stim(); s.ifpc = 16'h000c; step(s);

    // Reset while a redirect is pending
    s = br_stim(3'b000, 1, 16'h7000, 16'h7000, 16'h0022, 16'h0020);
    s.ack = 0;
    step(s);
    s = idle_stim(); step(s);
    do_reset();
    step(idle_stim());

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      s.adv  = ($urandom_range(0, 3) != 0);
      s.nop  = ($urandom_range(0, 9) == 0);
      s.br   = ($urandom_range(0, 2) != 0);
      s.unc  = !s.br && ($urandom_range(0, 1) == 1);
      s.nzp  = 3'($urandom);
      s.pred = 1'($urandom);
      s.tpc  = 16'($urandom);
      s.btb  = ($urandom_range(0, 3) != 0) ? s.tpc : 16'($urandom);
      s.pc   = 16'($urandom_range(0, 31));
      s.fpc  = s.pc + 16'd2;
      s.ccl  = ($urandom_range(0, 2) == 0);
      s.ccd  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      s.ifpc = 16'($urandom_range(0, 31));
      s.ack  = 1'($urandom);
      step(s);
    end

    @(negedge clk); #1;
    chk("queue_drain", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
